// File: rtl/sextium_sram_ctrl_pkg.sv
// Shared definitions for the Sextium SRAM controller: state encoding, default
// timing values and the state-to-strobe decode used by the FSM.
package sextium_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WS   = 3'd2,
    ST_WP   = 3'd3,
    ST_WH   = 3'd4,
    ST_ACK  = 3'd5
  } sram_state_e;

  localparam int DEF_READ_WAIT = 2;
  localparam int DEF_WR_SETUP  = 1;
  localparam int DEF_WR_PULSE  = 2;
  localparam int DEF_WR_HOLD   = 1;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
    logic ack;
  } strobe_t;

  // Strobe levels a given state presents to the SRAM and the core.
  function automatic strobe_t decode_strobes(sram_state_e st);
    strobe_t s;
    s = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0, ack: 1'b0};
    case (st)
      ST_RD: begin
        s.ce_n = 1'b0;
        s.oe_n = 1'b0;
      end
      ST_WS, ST_WH: begin
        s.ce_n  = 1'b0;
        s.dq_oe = 1'b1;
      end
      ST_WP: begin
        s.ce_n  = 1'b0;
        s.we_n  = 1'b0;
        s.dq_oe = 1'b1;
      end
      ST_ACK:  s.ack = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

  // Timing values must fit the 4-bit wait counter and be at least one cycle.
  function automatic logic timing_ok(int v);
    return (v >= 1) && (v <= 15);
  endfunction

endpackage

// File: rtl/sextium_sram_ctrl_wait_counter.sv
// Four-bit load/decrement wait counter with a zero flag, used to time each
// phase of an SRAM access.
module sextium_wait_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/sextium_sram_ctrl.sv
// Memory-side responder for the Sextium core: turns level-held read/write
// requests into timed accesses on an asynchronous 16-bit SRAM.
module sextium_sram_ctrl
  import sextium_sram_ctrl_pkg::*;
#(
  parameter int READ_WAIT = DEF_READ_WAIT,
  parameter int WR_SETUP  = DEF_WR_SETUP,
  parameter int WR_PULSE  = DEF_WR_PULSE,
  parameter int WR_HOLD   = DEF_WR_HOLD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr_bus,
  input  logic [15:0] mem_bus_out,
  output logic [15:0] mem_bus_in,
  output logic        mem_ack,
  output logic        proto_err,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  if (!timing_ok(READ_WAIT) || !timing_ok(WR_SETUP) ||
      !timing_ok(WR_PULSE)  || !timing_ok(WR_HOLD)) begin : g_bad_cfg
    $error("sextium_sram_ctrl: timing parameters must lie in 1..15");
  end

  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WS_LOAD = 4'(WR_SETUP - 1);
  localparam logic [3:0] WP_LOAD = 4'(WR_PULSE - 1);
  localparam logic [3:0] WH_LOAD = 4'(WR_HOLD - 1);

  sram_state_e state, state_nxt;
  strobe_t     strb_nxt;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic [3:0]  cnt_load_val;

  sextium_wait_counter u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Each timed phase counts down to zero, then preloads the next phase length.
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = 4'd0;
    cnt_dec      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_write) begin
          state_nxt    = ST_WS;
          cnt_load     = 1'b1;
          cnt_load_val = WS_LOAD;
        end else if (mem_read) begin
          state_nxt    = ST_RD;
          cnt_load     = 1'b1;
          cnt_load_val = RD_LOAD;
        end
      end
      ST_RD: begin
        if (cnt_zero) state_nxt = ST_ACK;
        else          cnt_dec   = 1'b1;
      end
      ST_WS: begin
        if (cnt_zero) begin
          state_nxt    = ST_WP;
          cnt_load     = 1'b1;
          cnt_load_val = WP_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WP: begin
        if (cnt_zero) begin
          state_nxt    = ST_WH;
          cnt_load     = 1'b1;
          cnt_load_val = WH_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WH: begin
        if (cnt_zero) state_nxt = ST_ACK;
        else          cnt_dec   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign strb_nxt = decode_strobes(state_nxt);

  // Strobes are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      mem_bus_in <= 16'h0000;
      mem_ack    <= 1'b0;
      proto_err  <= 1'b0;
      sram_addr  <= 16'h0000;
      sram_dq_o  <= 16'h0000;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      state      <= state_nxt;
      sram_ce_n  <= strb_nxt.ce_n;
      sram_oe_n  <= strb_nxt.oe_n;
      sram_we_n  <= strb_nxt.we_n;
      sram_dq_oe <= strb_nxt.dq_oe;
      mem_ack    <= strb_nxt.ack;
      if (state == ST_IDLE && mem_write) begin
        sram_addr <= addr_bus;
        sram_dq_o <= mem_bus_out;
        if (mem_read) proto_err <= 1'b1;
      end else if (state == ST_IDLE && mem_read) begin
        sram_addr <= addr_bus;
      end
      if (state == ST_RD && cnt_zero) mem_bus_in <= sram_dq_i;
    end
  end

endmodule

// File: tb/tb_sextium_sram_ctrl.sv
// Scoreboard bench for sextium_sram_ctrl: drives core requests, models the
// asynchronous SRAM and checks strobe timing, read data and written contents.
module tb_sextium_sram_ctrl;

  localparam int RD_LAT   = 3;
  localparam int WR_LAT   = 5;
  localparam int WR_SETUP = 1;
  localparam int WR_PULSE = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] addr_bus = 16'h0000;
  logic [15:0] mem_bus_out = 16'h0000;
  logic [15:0] mem_bus_in;
  logic        mem_ack;
  logic        proto_err;
  logic [15:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i = 16'h0000;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  sextium_sram_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .addr_bus    (addr_bus),
    .mem_bus_out (mem_bus_out),
    .mem_bus_in  (mem_bus_in),
    .mem_ack     (mem_ack),
    .proto_err   (proto_err),
    .sram_addr   (sram_addr),
    .sram_dq_o   (sram_dq_o),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_i   (sram_dq_i),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        is_rd;
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         sb_head;
  logic [15:0] sram_mem [logic [15:0]];
  logic [15:0] ref_mem  [logic [15:0]];
  int          num_checks = 0;
  int          num_fails = 0;
  logic        mon_en = 1'b0;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed 0x%04h, expected 0x%04h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] sram_preset(logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] sram_peek(logic [15:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : sram_preset(a);
  endfunction

  function automatic logic [15:0] ref_peek(logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : sram_preset(a);
  endfunction

  // Asynchronous SRAM: data appears half a cycle after CE/OE, writes land while WE is low.
  always @(negedge clock)
    sram_dq_i <= (!sram_ce_n && !sram_oe_n) ? sram_peek(sram_addr) : 16'h0000;

  always @(posedge clock)
    if (!reset && !sram_we_n && !sram_ce_n)
      sram_mem[sram_addr] = sram_dq_oe ? sram_dq_o : 16'hDEAD;

  // Bus invariants every cycle, and scoreboard retirement on each ack.
  always @(negedge clock) begin
    if (mon_en) begin
      checkOutput("oe_dq_excl", {15'd0, !sram_oe_n && sram_dq_oe}, 16'd0);
      checkOutput("we_bracket", {15'd0, !sram_we_n && (sram_ce_n || !sram_dq_oe || !sram_oe_n)}, 16'd0);
      if (mem_ack) begin
        checkOutput("ack_pending", {15'd0, sb_q.size() != 0}, 16'd1);
        if (sb_q.size() != 0) begin
          sb_head = sb_q.pop_front();
          if (sb_head.is_rd) checkOutput("rd_data", mem_bus_in, sb_head.data);
          else               checkOutput("wr_mem", sram_peek(sb_head.addr), sb_head.data);
        end
      end
    end
  end

  task automatic applyStimulus(input logic do_rd, input logic do_wr,
                               input logic [15:0] addr, input logic [15:0] data);
    int   lat;
    sb_t  e;
    logic exp_ce, exp_oe, exp_we, exp_dq, exp_ack;
    @(posedge clock); #1;
    mem_read    = do_rd;
    mem_write   = do_wr;
    addr_bus    = addr;
    mem_bus_out = data;
    if (do_wr) begin
      ref_mem[addr] = data;
      e   = '{is_rd: 1'b0, addr: addr, data: data};
      lat = WR_LAT;
    end else begin
      e   = '{is_rd: 1'b1, addr: addr, data: ref_peek(addr)};
      lat = RD_LAT;
    end
    sb_q.push_back(e);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        checkOutput("sram_addr", sram_addr, addr);
        addr_bus    = ~addr;
        mem_bus_out = ~data;
      end
      exp_ce  = (k < lat) ? 1'b0 : 1'b1;
      exp_ack = (k == lat);
      if (do_wr) begin
        exp_oe = 1'b1;
        exp_we = (k >= 1 + WR_SETUP && k <= WR_SETUP + WR_PULSE) ? 1'b0 : 1'b1;
        exp_dq = (k < lat);
      end else begin
        exp_oe = exp_ce;
        exp_we = 1'b1;
        exp_dq = 1'b0;
      end
      checkOutput($sformatf("strobes_%s_k%0d", do_wr ? "wr" : "rd", k),
                  {11'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_ack},
                  {11'd0, exp_ce, exp_oe, exp_we, exp_dq, exp_ack});
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    logic [15:0] a, d;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      checkOutput("idle_strobes", {11'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_ack}, 16'b11100);
      checkOutput("idle_bus_in", mem_bus_in, 16'h0000);
    end
    checkOutput("idle_proto_err", {15'd0, proto_err}, 16'd0);

    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h00FF, 16'hA5A5);
    checkOutput("bus_in_hold", mem_bus_in, 16'hBEEF);
    applyStimulus(1'b1, 1'b0, 16'h00FF, 16'h0000);

    // Back-to-back read, write, read on the same word.
    applyStimulus(1'b1, 1'b0, 16'h2000, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h2000, 16'h3C3C);
    applyStimulus(1'b1, 1'b0, 16'h2000, 16'h0000);

    for (int i = 0; i < 4; i++) begin
      a = 16'(16'h4000 + $urandom_range(0, 255));
      d = 16'($urandom_range(0, 65535));
      applyStimulus(1'b0, 1'b1, a, d);
      applyStimulus(1'b1, 1'b0, a, 16'h0000);
    end

    checkOutput("proto_err_clear", {15'd0, proto_err}, 16'd0);
    applyStimulus(1'b1, 1'b1, 16'h0456, 16'h7777);
    checkOutput("proto_err_set", {15'd0, proto_err}, 16'd1);
    applyStimulus(1'b1, 1'b0, 16'h0456, 16'h0000);
    checkOutput("proto_err_sticky", {15'd0, proto_err}, 16'd1);

    // Reset lands while WE is low; the access must vanish without an ack.
    @(posedge clock); #1;
    mem_write   = 1'b1;
    addr_bus    = 16'h0800;
    mem_bus_out = 16'h1111;
    repeat (2) @(posedge clock);
    #1 checkOutput("wp_reached", {15'd0, sram_we_n}, 16'd0);
    mem_write = 1'b0;
    reset     = 1'b1;
    @(posedge clock); #1;
    checkOutput("rst_strobes", {11'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_ack}, 16'b11100);
    checkOutput("rst_proto_err", {15'd0, proto_err}, 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checkOutput("post_rst_quiet", {14'd0, sram_ce_n, mem_ack}, 16'b10);
    end

    applyStimulus(1'b1, 1'b0, 16'h0800, 16'h0000);
    repeat (3) @(posedge clock);
    #1 checkOutput("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
